// File: rtl/compute_unit_pkg.sv
// Shared compute-unit definitions for the tensor-array scheduler
// and the push unit.
package compute_unit_pkg;

    localparam int ARRAY_DIM  = 4;
    localparam int FEED_STEPS = 2 * ARRAY_DIM - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Scans requests starting at the priority pointer.
module rr_arbiter #(
    parameter int NUM_WARPS = 4,
    parameter int IW        = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] i_req,
    input  logic [IW-1:0]        i_rr_ptr,
    output logic [NUM_WARPS-1:0] o_grant,
    output logic [IW-1:0]        o_grant_id,
    output logic                 o_valid
);

    logic [IW-1:0] w_idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_valid    = 1'b0;
        w_idx      = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            w_idx = IW'((int'(i_rr_ptr) + i) % NUM_WARPS);
            if (i_req[w_idx]) begin
                o_valid       = 1'b1;
                o_grant       = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_id    = w_idx;
            end
        end
    end

endmodule

// File: rtl/matmul_scheduler.sv
// Arbitrates the systolic tensor array between warps and sequences
// clear, operand feed, completion wait and result drain.
module matmul_scheduler
    import compute_unit_pkg::*;
#(
    parameter int NUM_WARPS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_WARPS-1:0]         req,
    input  logic                         operand_ready,
    input  logic                         array_done,
    input  logic                         wb_ready,
    output logic [NUM_WARPS-1:0]         grant,
    output logic [$clog2(NUM_WARPS)-1:0] grant_id,
    output logic                         busy,
    output logic                         array_clear,
    output logic                         push_valid,
    output logic                         pause,
    output logic [2:0]                   feed_step,
    output logic                         wb_valid,
    output logic [1:0]                   wb_row,
    output logic [NUM_WARPS-1:0]         done
);

    localparam int IW = $clog2(NUM_WARPS);
    localparam logic [2:0] LAST_STEP = 3'(FEED_STEPS - 1);
    localparam logic [1:0] LAST_ROW  = 2'(ARRAY_DIM - 1);

    sched_state_t         r_state;
    logic [NUM_WARPS-1:0] r_grant;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        r_rr_ptr;
    logic [2:0]           r_feed_step;
    logic [1:0]           r_wb_row;

    logic [NUM_WARPS-1:0] w_arb_grant;
    logic [IW-1:0]        w_arb_id;
    logic                 w_arb_valid;
    logic                 w_feed;

    rr_arbiter #(
        .NUM_WARPS (NUM_WARPS),
        .IW        (IW)
    ) u_arb (
        .i_req      (req),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_arb_grant),
        .o_grant_id (w_arb_id),
        .o_valid    (w_arb_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_feed_step <= '0;
            r_wb_row    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_arb_valid) begin
                        r_state     <= S_CLEAR;
                        r_grant     <= w_arb_grant;
                        r_owner     <= w_arb_id;
                        r_feed_step <= '0;
                        r_wb_row    <= '0;
                    end
                end
                S_CLEAR: r_state <= S_FEED;
                S_FEED: begin
                    if (operand_ready) begin
                        if (r_feed_step == LAST_STEP)
                            r_state <= S_WAIT;
                        else
                            r_feed_step <= r_feed_step + 3'd1;
                    end
                end
                S_WAIT: begin
                    if (array_done)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (wb_ready) begin
                        if (r_wb_row == LAST_ROW)
                            r_state <= S_DONE;
                        else
                            r_wb_row <= r_wb_row + 2'd1;
                    end
                end
                S_DONE: begin
                    // Priority moves past the warp just served.
                    r_rr_ptr <= (int'(r_owner) == NUM_WARPS - 1)
                              ? '0 : r_owner + IW'(1);
                    r_grant  <= '0;
                    r_owner  <= '0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_feed      = (r_state == S_FEED);
    assign grant       = r_grant;
    assign grant_id    = r_owner;
    assign busy        = (r_state != S_IDLE);
    assign array_clear = (r_state == S_CLEAR);
    assign push_valid  = w_feed && operand_ready;
    assign pause       = (r_state == S_CLEAR) || (w_feed && !operand_ready);
    assign feed_step   = r_feed_step;
    assign wb_valid    = (r_state == S_DRAIN);
    assign wb_row      = r_wb_row;
    assign done        = (r_state == S_DONE) ? r_grant : '0;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Self-checking bench for matmul_scheduler: transaction model
// plus directed scenarios with literal expectations.
module tb_matmul_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       operand_ready = 1'b0;
    logic       array_done = 1'b0;
    logic       wb_ready = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       array_clear;
    logic       push_valid;
    logic       pause;
    logic [2:0] feed_step;
    logic       wb_valid;
    logic [1:0] wb_row;
    logic [3:0] done;

    matmul_scheduler #(.NUM_WARPS(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .operand_ready (operand_ready),
        .array_done    (array_done),
        .wb_ready      (wb_ready),
        .grant         (grant),
        .grant_id      (grant_id),
        .busy          (busy),
        .array_clear   (array_clear),
        .push_valid    (push_valid),
        .pause         (pause),
        .feed_step     (feed_step),
        .wb_valid      (wb_valid),
        .wb_row        (wb_row),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle,1 clear,2 feed,3 wait,4 drain,5 done
    int m_phase = 0, m_owner = 0, m_ptr = 0;
    int m_fed = 0, m_wb = 0, m_wait = 0, m_fstall = 0, m_wstall = 0;

    // Responder knobs
    int stall_step = -1, stall_len = 0;
    int wstall_row = -1, wstall_len = 0;
    int done_delay = 4;

    // Observations of the DUT
    int cyc = 0, last_done_cyc = 0;
    bit seen_done = 0;
    int push_cnt, pause_cnt, wbv_cnt, clear_cnt;
    int done_cnt[4];
    int grant_log[$];
    int wb_acc[$];
    logic [3:0] last_grant;

    task automatic clr_obs();
        push_cnt = 0; pause_cnt = 0; wbv_cnt = 0; clear_cnt = 0;
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        wb_acc.delete();
    endtask

    always @(posedge clk) begin
        #1;
        operand_ready = !(m_phase == 2 && m_fed == stall_step
                          && m_fstall < stall_len);
        wb_ready = !(m_phase == 4 && m_wb == wstall_row
                     && m_wstall < wstall_len);
        array_done = (m_phase == 3 && m_wait >= done_delay);
    end

    always @(negedge clk) begin : cmp
        logic [3:0] e_grant;
        bit found;
        int w;
        cyc++;
        if (!reset_n) begin
            chk("reset_outs", 32'({grant, grant_id, busy, array_clear,
                push_valid, pause, feed_step, wb_valid, wb_row, done}), 0);
            m_phase = 0; m_ptr = 0; m_owner = 0;
        end else begin
            e_grant = (m_phase != 0) ? 4'(1 << m_owner) : 4'b0;
            chk("grant", 32'(grant), 32'(e_grant));
            chk("grant_id", 32'(grant_id), (m_phase != 0) ? m_owner : 0);
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("array_clear", 32'(array_clear), 32'(m_phase == 1));
            chk("push_valid", 32'(push_valid),
                32'(m_phase == 2 && operand_ready));
            chk("pause", 32'(pause),
                32'(m_phase == 1 || (m_phase == 2 && !operand_ready)));
            chk("wb_valid", 32'(wb_valid), 32'(m_phase == 4));
            chk("done", 32'(done), (m_phase == 5) ? 32'(e_grant) : 0);
            if (m_phase == 1 || m_phase == 2)
                chk("feed_step", 32'(feed_step), m_fed);
            if (m_phase == 1 || m_phase == 4)
                chk("wb_row", 32'(wb_row), m_wb);

            if (push_valid) push_cnt++;
            if (pause && !array_clear) pause_cnt++;
            if (wb_valid) wbv_cnt++;
            if (wb_valid && wb_ready) wb_acc.push_back(int'(wb_row));
            if (array_clear) begin
                clear_cnt++;
                grant_log.push_back(int'(grant_id));
                last_grant = grant;
                if (seen_done)
                    chk("idle_gap", 32'(cyc - last_done_cyc >= 2), 1);
            end
            if (done != 0) begin
                for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
                last_done_cyc = cyc;
                seen_done = 1;
            end

            case (m_phase)
                0: begin
                    found = 0;
                    for (int k = 0; k < 4; k++) begin
                        w = (m_ptr + k) % 4;
                        if (req[w[1:0]] && !found) begin
                            found = 1;
                            m_owner = w;
                        end
                    end
                    if (found) begin
                        m_phase = 1; m_fed = 0; m_wb = 0; m_wait = 0;
                        m_fstall = 0; m_wstall = 0;
                    end
                end
                1: m_phase = 2;
                2: if (operand_ready) begin
                       m_fed++;
                       if (m_fed == 7) m_phase = 3;
                   end else m_fstall++;
                3: if (array_done) m_phase = 4; else m_wait++;
                4: if (wb_ready) begin
                       m_wb++;
                       if (m_wb == 4) m_phase = 5;
                   end else m_wstall++;
                5: begin
                       m_ptr = (m_owner + 1) % 4;
                       m_phase = 0;
                   end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph, input string nm);
        int n = 0;
        while (m_phase != ph && n < 300) begin
            step();
            n++;
        end
        chk(nm, 32'(n < 300), 1);
    endtask

    task automatic wait_fed(input int f, input string nm);
        int n = 0;
        while (!(m_phase == 2 && m_fed >= f) && n < 300) begin
            step();
            n++;
        end
        chk(nm, 32'(n < 300), 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(m_phase == 0 && !busy) && n < 400) begin
            step();
            n++;
        end
        chk(nm, 32'(n < 400), 1);
    endtask

    task automatic run_op(input logic [3:0] mask, input string nm);
        clr_obs();
        req = mask;
        wait_phase(2, {nm, "_to_feed"});
        req = 4'b0;
        wait_idle({nm, "_to_idle"});
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n, base;
        clr_obs();
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // All warps requesting: rotation from pointer 0
        clr_obs();
        base = grant_log.size();
        req = 4'b1111;
        n = 0;
        while (grant_log.size() < base + 5 && n < 300) begin
            step();
            n++;
        end
        chk("rr_timeout", 32'(n < 300), 1);
        req = 4'b0;
        wait_idle("rr_to_idle");
        for (int i = 0; i < 5; i++)
            if (base + i < grant_log.size())
                chk($sformatf("rr_order%0d", i), grant_log[base + i], exp_rr[i]);
        chk("rr_done0", done_cnt[0], 2);
        chk("rr_done3", done_cnt[3], 1);

        // Single request from warp 2, no stalls
        run_op(4'b0100, "single");
        chk("single_grant", 32'(last_grant), 32'b0100);
        chk("single_clear", clear_cnt, 1);
        chk("single_push", push_cnt, 7);
        chk("single_done2", done_cnt[2], 1);
        chk("single_rows", wb_acc.size(), 4);
        for (int i = 0; i < 4 && i < wb_acc.size(); i++)
            chk($sformatf("single_row%0d", i), wb_acc[i], i);

        // Operand stall on step 3 for two cycles
        stall_step = 3; stall_len = 2;
        run_op(4'b0010, "fstall");
        stall_step = -1; stall_len = 0;
        chk("fstall_push", push_cnt, 7);
        chk("fstall_pause", pause_cnt, 2);
        chk("fstall_done1", done_cnt[1], 1);

        // Writeback stall on row 1 for three cycles
        wstall_row = 1; wstall_len = 3;
        run_op(4'b1000, "wstall");
        wstall_row = -1; wstall_len = 0;
        chk("wstall_wbv", wbv_cnt, 7);
        chk("wstall_done3", done_cnt[3], 1);
        chk("wstall_rows", wb_acc.size(), 4);

        // Owner drops request in the middle of feed
        clr_obs();
        req = 4'b0001;
        wait_fed(3, "drop_mid_feed");
        req = 4'b0;
        wait_idle("drop_to_idle");
        chk("drop_push", push_cnt, 7);
        chk("drop_done0", done_cnt[0], 1);

        // Reset during drain, then pointer restarts at 0
        clr_obs();
        req = 4'b0100;
        wait_phase(4, "rst_to_drain");
        req = 4'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_async", 32'({busy, wb_valid, grant, done, pause}), 0);
        repeat (2) step();
        chk("rst_no_done", done_cnt[2], 0);
        reset_n = 1'b1;
        step();
        base = grant_log.size();
        req = 4'b1001;
        n = 0;
        while (grant_log.size() == base && n < 50) begin
            step();
            n++;
        end
        chk("post_rst_grant_timeout", 32'(n < 50), 1);
        req = 4'b0;
        wait_idle("post_rst_idle");
        if (grant_log.size() > base)
            chk("post_rst_owner", grant_log[base], 0);
        chk("post_rst_done0", done_cnt[0], 1);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_scheduler.md
# matmul_scheduler

Arbitrates the compute unit's single 4x4 systolic tensor array between warps. Sequences each granted matmul: clears the array's step counter, feeds operand rows to the push unit under operand-ready stalls, waits for the array's done flag, then drains result rows to the register-file writeback port. It sits between the warp scheduler/register file and the push unit.

## Interface
- NUM_WARPS, 4: number of requesting warps (2..8)
- ARRAY_DIM, 4: systolic array edge; FEED_STEPS = 2*ARRAY_DIM-1 = 7
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_WARPS  level request per warp for a matmul
- operand_ready  in  1  granted warp's operand row for feed_step is valid this cycle
- array_done  in  1  push unit matmul_done level
- wb_ready  in  1  register file accepts the current result row
- grant  out  NUM_WARPS  one-hot owner of the array; 0 when idle
- grant_id  out  $clog2(NUM_WARPS)  binary index of owner; 0 when idle
- busy  out  1  state != IDLE
- array_clear  out  1  one-cycle pulse; synchronously clears the push unit step counter
- push_valid  out  1  to push unit; row data on load_data is valid
- pause  out  1  to push unit; freezes the array
- feed_step  out  3  operand row index 0..FEED_STEPS-1 the register file must present
- wb_valid  out  1  result row presented to writeback
- wb_row  out  2  result row index 0..ARRAY_DIM-1
- done  out  NUM_WARPS  one-cycle completion pulse to the owning warp

## Operation
- States: IDLE, CLEAR, FEED, WAIT, DRAIN, DONE.
- IDLE: if req != 0, round-robin pick starting at rr_ptr; latch owner; -> CLEAR.
- CLEAR (1 cycle): grant valid, array_clear=1, pause=1, push_valid=0; -> FEED.
- FEED: push_valid=operand_ready, pause=!operand_ready; feed_step increments on each cycle with operand_ready. On the accepted step FEED_STEPS-1 -> WAIT.
- WAIT: push_valid=0, pause=0; stays until array_done=1 -> DRAIN.
- DRAIN: wb_valid=1, wb_row starts at 0; advances when wb_valid&&wb_ready. Acceptance of row ARRAY_DIM-1 -> DONE.
- DONE (1 cycle): done[owner]=1; rr_ptr = owner+1 mod NUM_WARPS; grant released; -> IDLE.
- Owner's req dropping after grant is ignored; the operation runs to completion.
- A req still high in DONE is not served that cycle; it competes in the next IDLE cycle behind higher rr priority.
- feed_step and wb_row hold their values during stalls and reset to 0 on entry to CLEAR.

## Timing
- Reset (reset_n=0, async): state IDLE, rr_ptr 0; every output 0, including pause and array_clear.
- Reset mid-operation aborts it without a done pulse. The push unit is reset by the same reset.
- req to grant: 1 cycle (IDLE to CLEAR registered). Grant stays stable from CLEAR through DONE inclusive.
- No-stall matmul: 1 IDLE + 1 CLEAR + 7 FEED + WAIT (until array_done) + 4 DRAIN + 1 DONE.
- All outputs are registered-state decodes. Only push_valid, pause (FEED) and the wb_row advance depend combinationally on inputs.
- Back-to-back requests from the same warp are separated by at least one IDLE cycle.

## Structure
- compute_unit_pkg: sched_state_t enum, ARRAY_DIM, FEED_STEPS constants (shared with the push unit).
- Sub-module rr_arbiter: req, rr_ptr -> one-hot grant plus index; purely combinational, parameterised by NUM_WARPS.

## Test plan
- Single req[2], operand_ready=1, wb_ready=1, array_done 4 cycles after WAIT entry -> grant=4'b0100, array_clear for 1 cycle, push_valid for 7 cycles, wb_row 0..3, done[2] once.
- req=4'b1111 held -> grants in order 0,1,2,3,0; each done precedes the next grant by at least 1 IDLE cycle.
- operand_ready low on feed_step 3 for 2 cycles -> pause=1, push_valid=0, feed_step held at 3; push_valid totals exactly 7.
- wb_ready low on row 1 for 3 cycles -> wb_valid high, wb_row held at 1; done fires only after row 3 is accepted.
- Owner drops req during FEED -> the operation completes normally and done is still pulsed.
- reset_n low during DRAIN -> all outputs 0 immediately; no done; next req is served from rr_ptr 0.
